// File: rtl/shift_reg_sync_set_clr.sv
// Universal register: hold, shift right, shift left or parallel load.
// Synchronous clear beats synchronous set, and both beat the clock enable.
// rst_n is asynchronous and active low. It loads RESET_VALUE.
// Optional feature macro: SHIFT_REG_ROTATE_EN. When it is defined, the rot input
// turns both shifts into rotates.
module shift_reg_sync_set_clr #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l
);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeShr   = 2'b01,
    ModeShl   = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             fill_r;
  logic             fill_l;
  mode_e            mode_dec;

  assign mode_dec = mode_e'(mode);

  // Pick the bit that enters on each shift: serial input, or the outgoing bit when rotating.
  always_comb begin
    fill_r = sin_r;
    fill_l = sin_l;
`ifdef SHIFT_REG_ROTATE_EN
    if (rot) begin
      fill_r = q_reg[0];
      fill_l = q_reg[WIDTH-1];
    end
`endif
  end

  // Next-state priority: clear, then set, then enable-gated mode operation.
  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else if (set) begin
      q_next = SET_VALUE;
    end else if (en) begin
      case (mode_dec)
        ModeHold: q_next = q_reg;
        ModeShr:  q_next = {fill_r, q_reg[WIDTH-1:1]};
        ModeShl:  q_next = {q_reg[WIDTH-2:0], fill_l};
        ModeLoad: q_next = d;
        default:  q_next = q_reg;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q      = q_reg;
  assign sout_r = q_reg[0];
  assign sout_l = q_reg[WIDTH-1];

endmodule
